// File: rtl/demux16_rx.sv
// demux16_rx: serial time-division receiver. It collects 16 slots into a
// holding register and then publishes them as a parallel word on w.
// The parameter LSB_FIRST selects where each slot lands: 1 puts slot k in w[k],
// and 0 puts slot k in w[15-k].
// When the macro DEMUX16_PARITY_EN is defined, the block adds a 17th slot that
// carries an even-parity bit, and the word is published only if that bit checks.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for sync; enabled non-sync slots are dropped
// RUN     | capturing slots 1..15 into the holding register
// PAR     | waiting for the parity slot (DEMUX16_PARITY_EN only)
module demux16_rx #(
    parameter int LSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    input  logic        sync,
    input  logic        en,
    output logic [15:0] w,
    output logic [3:0]  s,
    output logic        valid,
    output logic        err,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
`ifdef DEMUX16_PARITY_EN
    localparam logic [1:0] ST_PAR  = 2'd2;
`endif

    logic [1:0]  state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] w_q, w_d;
    logic [3:0]  s_q, s_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    // The holding register always stores slots in arrival order.
    // The bit ordering chosen by LSB_FIRST is applied only when the word is published.
    function automatic logic [15:0] map_slots(input logic [15:0] h);
        logic [15:0] r;
        r = h;
        if (LSB_FIRST == 0) begin
            for (int k = 0; k < 16; k++) begin
                r[15-k] = h[k];
            end
        end
        return r;
    endfunction

    // Next-state logic: slot capture, frame completion, premature-sync and parity handling
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        w_d     = w_q;
        s_d     = s_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (en) begin
            if (sync) begin
                // A sync in any state other than IDLE aborts the current partial frame.
                err_d   = (state_q != ST_IDLE);
                hold_d  = {15'd0, din};
                s_d     = 4'd1;
                state_d = ST_RUN;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        hold_d[s_q] = din;
                        if (s_q == 4'd15) begin
                            s_d = 4'd0;
`ifdef DEMUX16_PARITY_EN
                            state_d = ST_PAR;
`else
                            state_d = ST_IDLE;
                            w_d     = map_slots(hold_d);
                            valid_d = 1'b1;
`endif
                        end else begin
                            s_d = s_q + 4'd1;
                        end
                    end
`ifdef DEMUX16_PARITY_EN
                    ST_PAR: begin
                        state_d = ST_IDLE;
                        if (din == ^hold_q) begin
                            w_d     = map_slots(hold_q);
                            valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hold_q  <= 16'h0000;
            w_q     <= 16'h0000;
            s_q     <= 4'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            w_q     <= w_d;
            s_q     <= s_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign w     = w_q;
    assign s     = s_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_demux16_rx.sv
// Bench for demux16_rx. Two instances share the same stimulus: one is built with
// LSB_FIRST=1 and the other with LSB_FIRST=0.
// The reference model keeps the current frame as a queue of received slot bits.
module tb_demux16_rx;

`ifdef DEMUX16_PARITY_EN
    localparam int FRAME_LEN = 17;
`else
    localparam int FRAME_LEN = 16;
`endif

    logic        clk = 1'b0;
    logic        reset, din, sync, en;
    logic [15:0] w0, w1;
    logic [3:0]  s0, s1;
    logic        valid0, valid1, err0, err1, busy0, busy1;

    demux16_rx #(.LSB_FIRST(1)) dut_lsb (
        .clk(clk), .reset(reset), .din(din), .sync(sync), .en(en),
        .w(w0), .s(s0), .valid(valid0), .err(err0), .busy(busy0)
    );

    demux16_rx #(.LSB_FIRST(0)) dut_msb (
        .clk(clk), .reset(reset), .din(din), .sync(sync), .en(en),
        .w(w1), .s(s1), .valid(valid1), .err(err1), .busy(busy1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int vcount = 0;

    // Reference model state
    bit          act;
    bit          q[$];
    logic [15:0] mw;
    logic        mv, me;

    typedef struct {
        logic       en, sync, din;
        logic [3:0] s;
        logic       valid, err, busy;
    } vec_t;
    vec_t tbl[7];

    function automatic void chk(string nm, logic [15:0] a, logic [15:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, a, e, $time);
        end
    endfunction

    function automatic logic [15:0] rev16(logic [15:0] v);
        logic [15:0] r;
        for (int k = 0; k < 16; k++) r[15-k] = v[k];
        return r;
    endfunction

    function automatic void model_reset();
        act = 0;
        q.delete();
        mw = 16'h0000;
        mv = 0;
        me = 0;
    endfunction

    function automatic void model_step(logic d, logic sy, logic e);
        logic [15:0] word;
        mv = 0;
        me = 0;
        if (!e) return;
        if (sy) begin
            me = act;
            act = 1;
            q.delete();
            q.push_back(d);
        end else if (act) begin
            q.push_back(d);
            if (q.size() == FRAME_LEN) begin
                word = 16'h0000;
                for (int k = 0; k < 16; k++) word[k] = q[k];
                if (FRAME_LEN == 16 || q[16] == ^word) begin
                    mw = word;
                    mv = 1;
                end else begin
                    me = 1;
                end
                act = 0;
                q.delete();
            end
        end
    endfunction

    task automatic compare_all();
        logic [3:0] es;
        es = (act && q.size() < 16) ? 4'(q.size()) : 4'd0;
        chk("w_lsb", w0, mw);
        chk("w_msb", w1, rev16(mw));
        chk("s_lsb", 16'(s0), 16'(es));
        chk("s_msb", 16'(s1), 16'(es));
        chk("valid_lsb", 16'(valid0), 16'(mv));
        chk("valid_msb", 16'(valid1), 16'(mv));
        chk("err_lsb", 16'(err0), 16'(me));
        chk("err_msb", 16'(err1), 16'(me));
        chk("busy_lsb", 16'(busy0), 16'(act));
        chk("busy_msb", 16'(busy1), 16'(act));
        if (valid0) vcount++;
    endtask

    task automatic step(input logic e, input logic sy, input logic d);
        @(negedge clk);
        en = e;
        sync = sy;
        din = d;
        @(posedge clk);
        model_step(d, sy, e);
        #1 compare_all();
    endtask

    // Sends a frame of nslots slots starting with sync. When toggle is set, an
    // en=0 cycle carrying random garbage is inserted before every slot.
    task automatic send_frame(input logic [15:0] word, input bit toggle, input int nslots, input logic par);
        for (int k = 0; k < nslots; k++) begin
            if (toggle) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step(1'b1, k == 0, (k < 16) ? word[k] : par);
        end
    endtask

    // Asserts reset asynchronously in the middle of a cycle, checks the
    // immediate effect, and releases reset just after the next rising edge.
    task automatic mid_reset();
        #3 reset = 1'b1;
        #1 model_reset();
        compare_all();
        chk("reset_w_zero", w0, 16'h0000);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        en = 1'b0;
        sync = 1'b0;
        din = 1'b0;

        tbl[0] = '{en:1, sync:0, din:1, s:0, valid:0, err:0, busy:0};
        tbl[1] = '{en:0, sync:1, din:1, s:0, valid:0, err:0, busy:0};
        tbl[2] = '{en:1, sync:1, din:1, s:1, valid:0, err:0, busy:1};
        tbl[3] = '{en:0, sync:0, din:0, s:1, valid:0, err:0, busy:1};
        tbl[4] = '{en:1, sync:0, din:0, s:2, valid:0, err:0, busy:1};
        tbl[5] = '{en:1, sync:1, din:0, s:1, valid:0, err:1, busy:1};
        tbl[6] = '{en:0, sync:1, din:1, s:1, valid:0, err:0, busy:1};

        repeat (2) @(posedge clk);
        #1 model_reset();
        compare_all();
        reset = 1'b0;

        // The sync arrives on the first edge after reset; en stays high for the whole frame.
        vcount = 0;
        send_frame(16'hA5C3, 0, FRAME_LEN, ^16'hA5C3);
        chk("a5c3_w_lsb", w0, 16'hA5C3);
        chk("a5c3_w_msb", w1, 16'hC3A5);
        chk("a5c3_valid_count", 16'(vcount), 16'd1);

        // Table vectors, starting from IDLE.
        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].sync, tbl[i].din);
            chk($sformatf("tbl%0d_s", i), 16'(s0), 16'(tbl[i].s));
            chk($sformatf("tbl%0d_valid", i), 16'(valid0), 16'(tbl[i].valid));
            chk($sformatf("tbl%0d_err", i), 16'(err0), 16'(tbl[i].err));
            chk($sformatf("tbl%0d_busy", i), 16'(busy0), 16'(tbl[i].busy));
        end
        mid_reset();

        // The same frame again, with en toggling every cycle.
        vcount = 0;
        send_frame(16'hA5C3, 1, FRAME_LEN, ^16'hA5C3);
        chk("toggle_w", w0, 16'hA5C3);
        chk("toggle_valid_count", 16'(vcount), 16'd1);

        // A premature sync lands at slot 7; a full 1234 frame starts on that same cycle.
        send_frame(16'hBEEF, 0, 7, 1'b0);
        vcount = 0;
        step(1'b1, 1'b1, 1'b0);
        chk("premature_err", 16'(err0), 16'd1);
        chk("premature_w_held", w0, 16'hA5C3);
        for (int k = 1; k < FRAME_LEN; k++) step(1'b1, 1'b0, (k < 16) ? 1'((16'h1234 >> k) & 1) : ^16'h1234);
        chk("after_premature_w", w0, 16'h1234);
        chk("after_premature_valid_count", 16'(vcount), 16'd1);

        // Reset arrives at slot 9 of an FFFF frame; a clean 00FF frame follows.
        vcount = 0;
        send_frame(16'hFFFF, 0, 9, 1'b0);
        mid_reset();
        chk("abort_s", 16'(s0), 16'd0);
        send_frame(16'h00FF, 0, FRAME_LEN, ^16'h00FF);
        chk("00ff_w", w0, 16'h00FF);
        chk("abort_valid_count", 16'(vcount), 16'd1);

        // Two frames sent back to back, with no gap between them.
        send_frame(16'h8001, 0, FRAME_LEN, ^16'h8001);
        send_frame(16'h7E5A, 0, FRAME_LEN, ^16'h7E5A);
        chk("b2b_w", w0, 16'h7E5A);

`ifdef DEMUX16_PARITY_EN
        send_frame(16'h0001, 0, FRAME_LEN, 1'b1);
        chk("par_good_w", w0, 16'h0001);
        chk("par_good_valid", 16'(valid0), 16'd1);
        send_frame(16'hFFFF, 0, FRAME_LEN, 1'b1);
        chk("par_ffff_w", w0, 16'h0001);
        send_frame(16'h0001, 0, 16, 1'b0);
        chk("par_state_s", 16'(s0), 16'd0);
        chk("par_state_busy", 16'(busy0), 16'd1);
        step(1'b1, 1'b0, 1'b0);
        chk("par_bad_err", 16'(err0), 16'd1);
        chk("par_bad_w", w0, 16'h0001);
        send_frame(16'h0003, 0, 16, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("par_sync_err", 16'(err0), 16'd1);
`endif

        // Random traffic, checked against the model on every cycle.
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux16_rx.md
DEMUX16_RX -- requirements
Module: demux16_rx

Interface
REQ-001 The module SHALL have parameter LSB_FIRST, default 1; 1 routes slot k to w[k], 0 routes slot k to w[15-k].
REQ-002 The module SHALL have port clk, input, 1, the single rising-edge clock for all state.
REQ-003 The module SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The module SHALL have port din, input, 1, serial time-division data, one slot per enabled cycle.
REQ-005 The module SHALL have port sync, input, 1, high in the cycle carrying slot 0 of a frame.
REQ-006 The module SHALL have port en, input, 1, slot strobe; din/sync are ignored when low.
REQ-007 The module SHALL have port w, output, 16, last complete demultiplexed word (registered).
REQ-008 The module SHALL have port s, output, 4, index of the next slot to be captured (registered).
REQ-009 The module SHALL have port valid, output, 1, one-cycle pulse marking a new w.
REQ-010 The module SHALL have port err, output, 1, one-cycle pulse marking a frame/parity error.
REQ-011 The module SHALL have port busy, output, 1, high while a frame is in progress (state not IDLE).

Function
REQ-012 The block SHALL implement states IDLE, RUN and (with parity) PAR; all outputs registered.
REQ-013 In IDLE, a cycle with en=1 and sync=1 SHALL capture din as slot 0, set s=1, enter RUN.
REQ-014 In IDLE, en=1 with sync=0 SHALL discard din, leave s=0, and raise no err.
REQ-015 In RUN, en=1 and sync=0 SHALL capture din into holding bit s, increment s.
REQ-016 Cycles with en=0 SHALL change no state, no holding bit, no s; valid/err SHALL be 0.
REQ-017 Capturing slot 15 (no parity) SHALL load w with all 16 held bits, pulse valid in the next cycle, set s=0, return to IDLE.
REQ-018 Latency: valid and new w SHALL appear on the clock edge after the cycle sampling slot 15 (or parity slot).
REQ-019 In RUN, en=1 and sync=1 (premature sync, s!=0) SHALL pulse err, discard the partial frame, capture din as slot 0, set s=1, stay RUN.
REQ-020 w SHALL retain its previous value on any error or aborted frame.
REQ-021 Back-to-back frames SHALL be accepted: sync on the enabled cycle immediately after slot 15 starts the next frame with no gap.
REQ-022 The holding register SHALL be separate from w so w is stable throughout reception.

Reset
REQ-023 Asserting reset SHALL immediately force w=16'h0000, s=0, valid=0, err=0, busy=0, holding register=0, state IDLE.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame with no valid or err pulse.
REQ-025 After reset deassertion the block SHALL accept a frame whose sync arrives in the first clock cycle.

Configuration
REQ-026 Macro DEMUX16_PARITY_EN defined SHALL add a 17th slot: after slot 15 the block enters PAR, s reads 0, busy stays 1.
REQ-027 With DEMUX16_PARITY_EN, the enabled PAR cycle SHALL compare din to even parity (XOR of 16 bits): match loads w and pulses valid; mismatch pulses err, w held; both return to IDLE.
REQ-028 With DEMUX16_PARITY_EN, sync=1 in PAR SHALL be treated as a premature sync per REQ-019.
REQ-029 Without DEMUX16_PARITY_EN, no PAR state or parity logic SHALL exist and frames are 16 slots.

Verification
REQ-030 Reset, then sync+en with serial pattern of 16'hA5C3 (LSB first, en=1 continuously) -> w=16'hA5C3, valid one cycle after slot 15, err=0.
REQ-031 Same frame with en toggled 0/1 every cycle -> identical w=16'hA5C3, valid once, s holds during en=0 cycles.
REQ-032 Sync reasserted at slot 7 of a frame, then full frame 16'h1234 -> err pulse at slot-7 edge, then w=16'h1234, valid once.
REQ-033 Reset asserted at slot 9 of frame 16'hFFFF -> w=0, s=0, no valid; next frame 16'h00FF -> w=16'h00FF.
REQ-034 With DEMUX16_PARITY_EN, frame 16'h0001 + parity bit 1 -> valid, w=16'h0001; same frame + parity 0 -> err, w unchanged.
REQ-035 LSB_FIRST=0 with frame slots carrying 16'hA5C3 LSB first -> w=16'hC3A5 bit-reversed (16'hC3A5 reversed per bit = slot k at w[15-k]).
